cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Parametrised successor to the OV7670 capture front-end.
- Samples the DVP bus (vsync/href/data) on pclk and assembles 1- or 2-byte pixels.
- Optionally decimates in both axes and writes pixels as a linear write stream into the frame buffer.
- Adds frame handshaking, enable gating and line-length/frame-abort error detection.

Parameters:
H_FRAME, 320, active pixels per line (sensor side)
V_FRAME, 240, active lines per frame (sensor side)
BYTES_PER_PIXEL, 2, bytes per pixel on the bus; legal values 1 or 2
DECIM, 1, decimation factor for both axes; legal values 1, 2 or 4
ADDR_W, 17, frame-buffer address width; must hold (H_FRAME/DECIM)*(V_FRAME/DECIM)-1
VSYNC_POL, 1, active level of vsync

Ports:
pclk  in  1  pixel clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
enable  in  1  arm capture; sampled only in IDLE
vsync  in  1  frame sync from sensor
href  in  1  line valid from sensor
data  in  8  sensor byte bus
we  out  1  one-cycle write strobe, aligned with addr/pixel
addr  out  ADDR_W  frame-buffer word address
pixel  out  16  assembled pixel; 1-byte mode = {8'h00, byte}
frame_start  out  1  one-cycle pulse on first active href of a frame
frame_done  out  1  one-cycle pulse after the last pixel of a complete frame is written
busy  out  1  high from vsync-active detection until frame_done or abort
err_short  out  1  sticky: a line ended before H_FRAME pixels
err_long  out  1  sticky: href stayed high beyond H_FRAME pixels
err_abort  out  1  sticky: vsync went active mid-frame

Behaviour:
- Reset values: all outputs 0; internal row, col and byte phase 0; state IDLE.
- Sticky errors clear at the next frame_start, or on reset.

FSM states:
- IDLE: if enable, go to WAIT_VS.
- WAIT_VS: wait for vsync active; then busy=1 and go to WAIT_VS_END.
- WAIT_VS_END: wait for vsync inactive; go to WAIT_HREF.
- WAIT_HREF: href high goes to CAPTURE. The byte present in the same cycle is byte 0 of the line. frame_start pulses on row 0.
- CAPTURE: while href high, one byte per cycle.
  - First byte goes to pixel[15:8]; second byte goes to pixel[7:0].
  - In 1-byte mode, every byte completes a pixel.
  - On pixel completion: if col%DECIM==0 and row%DECIM==0, then we=1 on the next posedge with addr and pixel valid (latency: 1 pclk after the last byte is sampled).
  - col increments per completed pixel.
- CAPTURE exit:
  - href low with col<H_FRAME: set err_short. Set addr for the next kept row to row_base + H_FRAME/DECIM so the image stays aligned. Go to LINE_END.
  - col==H_FRAME with href still high: set err_long. Discard bytes until href low (no we). Go to LINE_END.
  - href low with col==H_FRAME: go to LINE_END.
- LINE_END:
  - If row==V_FRAME-1: pulse frame_done, busy=0, reset row/col/addr to 0. Go to WAIT_VS if enable, else IDLE.
  - Otherwise: row+1, col=0, go to WAIT_HREF.

Addressing and arithmetic:
- addr increments by 1 after each we.
- Last address written = (H_FRAME/DECIM)*(V_FRAME/DECIM)-1. It never wraps within a frame.
- col width is clog2(H_FRAME+1); row width is clog2(V_FRAME).

Boundary and special cases:
- vsync active during WAIT_HREF, CAPTURE or LINE_END before row V_FRAME-1 completes:
  - set err_abort, no frame_done, no we in that cycle;
  - reset row/col/addr; go to WAIT_VS_END (restarts capture of the new frame).
- Odd byte count in 2-byte mode when href falls: the half-pixel is dropped and treated as a short line.
- enable deasserted mid-frame: the current frame completes; then go to IDLE.
- Reset mid-frame: immediate return to IDLE, outputs 0.

Decomposition:
- Package cam_pkg: FSM state enum, BYTE_MODE_1/BYTE_MODE_2 constants, a clog2 function, and a function computing the pixel count per frame.
- Sub-module cam_byte_packer: byte-phase toggle, hi/lo byte register, and pixel-complete strobe. The parent FSM owns row/col/addr, decimation and errors.

Test Plan:
- H=4, V=3, BPP=2, DECIM=1; clean frame, bytes 0x01..0x18 → 12 writes, addr 0..11. First pixel 0x0102, last 0x1718. One frame_start, one frame_done; no errors.
- Same params, BPP=1 → bytes 0x01..0x0C produce pixels 0x0001..0x000C at addr 0..11.
- H=4, V=4, DECIM=2 → writes only on rows 0/2, cols 0/2. 4 writes at addr 0..3, then frame_done.
- Row 1 gives only 3 pixels (6 bytes) → err_short=1. Row 2 first pixel lands at addr 8. frame_done still pulses.
- Row 0 href held for 10 bytes with H=4, BPP=2 → 4 writes only, err_long=1, row 1 begins at addr 4.
- vsync asserted during row 1 → err_abort=1, no frame_done. The next full frame restarts at addr 0 and clears err_abort at its frame_start.

Source files
------------

// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the DVP camera capture front-end: FSM state
// encoding, byte-per-pixel mode constants and small elaboration-time helpers
// used to size counters and bound the frame-buffer address range.
// ---------------------------------------------------------------------------
package cam_pkg;

  // Capture FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_VS_END,
    ST_WAIT_HREF,
    ST_CAPTURE,
    ST_LINE_END
  } cam_state_e;

  // Legal BYTES_PER_PIXEL settings
  localparam int BYTE_MODE_1 = 1;
  localparam int BYTE_MODE_2 = 2;

  // Ceiling log2 with a floor of 1 so a degenerate size still yields a legal vector
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

  // Number of pixels actually stored per frame after decimation in both axes
  function automatic int pixels_per_frame(input int h, input int v, input int decim);
    return (h / decim) * (v / decim);
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// ---------------------------------------------------------------------------
// cam_byte_packer
// Turns the sensor byte stream into pixels. In 2-byte mode the first byte of
// each pair is held as the high byte and the second completes the pixel; in
// 1-byte mode every byte is a pixel, zero-extended to 16 bits.
//
// Ports:
//   i_pclk          pixel clock
//   i_rst           asynchronous active-high reset
//   i_clear         drop any half-assembled pixel (line end / abort)
//   i_byteValid     i_data carries a byte belonging to the current line
//   i_data          sensor byte
//   o_pixComplete   combinational: this byte completes a pixel
//   o_pixel         assembled pixel, valid while o_pixComplete is high
// ---------------------------------------------------------------------------
module cam_byte_packer
  import cam_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byteValid,
  input  logic [7:0]  i_data,
  output logic        o_pixComplete,
  output logic [15:0] o_pixel
);

  logic       r_phase;
  logic [7:0] r_hiByte;

  // Byte phase only ever toggles in 2-byte mode; clear wins over a new byte
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_phase  <= 1'b0;
      r_hiByte <= 8'h00;
    end else if (i_clear) begin
      r_phase  <= 1'b0;
    end else if (i_byteValid && (BYTES_PER_PIXEL == BYTE_MODE_2)) begin
      if (!r_phase) r_hiByte <= i_data;
      r_phase <= ~r_phase;
    end
  end

  // Completion is combinational so the parent can register we/pixel on the
  // same edge that samples the last byte
  always_comb begin
    o_pixComplete = 1'b0;
    o_pixel       = 16'h0000;
    if (BYTES_PER_PIXEL == BYTE_MODE_1) begin
      o_pixComplete = i_byteValid && !i_clear;
      o_pixel       = {8'h00, i_data};
    end else begin
      o_pixComplete = i_byteValid && !i_clear && r_phase;
      o_pixel       = {r_hiByte, i_data};
    end
  end

endmodule

// File: rtl/cam_capture.sv
// ---------------------------------------------------------------------------
// cam_capture
// DVP camera capture front-end. Follows vsync/href, assembles pixels via
// cam_byte_packer, optionally decimates both axes and emits a linear write
// stream into a frame buffer, with frame handshakes and sticky error flags.
//
// Ports:
//   pclk, rst              pixel clock, asynchronous active-high reset
//   enable                 arm capture (sampled in IDLE and at frame end)
//   vsync, href, data      sensor DVP bus
//   we, addr, pixel        frame-buffer write stream (registered)
//   frame_start            pulse on first active href of a frame
//   frame_done             pulse after the last pixel of a complete frame
//   busy                   frame in progress
//   err_short/long/abort   sticky line-length and frame-abort errors
// ---------------------------------------------------------------------------
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_FRAME         = 320,
  parameter int V_FRAME         = 240,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int DECIM           = 1,
  parameter int ADDR_W          = 17,
  parameter bit VSYNC_POL       = 1'b1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       pixel,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              err_short,
  output logic              err_long,
  output logic              err_abort
);

  localparam int COL_W        = clog2(H_FRAME + 1);
  localparam int ROW_W        = clog2(V_FRAME);
  localparam int H_OUT        = H_FRAME / DECIM;
  localparam int FRAME_PIXELS = pixels_per_frame(H_FRAME, V_FRAME, DECIM);

  cam_state_e        r_state;
  cam_state_e        w_nextState;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_nextAddr;
  logic [ADDR_W-1:0] r_rowBase;

  logic        w_vsActive;
  logic        w_lastRow;
  logic        w_lineFull;
  logic        w_abort;
  logic        w_byteValid;
  logic        w_clear;
  logic        w_keepRow;
  logic        w_keepCol;
  logic        w_write;
  logic        w_pixComplete;
  logic [15:0] w_pixel;

  assign w_vsActive = (vsync == VSYNC_POL);
  assign w_lastRow  = (r_row == ROW_W'(V_FRAME - 1));
  assign w_lineFull = (r_col == COL_W'(H_FRAME));

  // A fresh vsync inside the active area restarts capture; once the last row
  // has ended the frame counts as complete and vsync is no longer an abort
  assign w_abort = w_vsActive &&
                   ((r_state == ST_WAIT_HREF) || (r_state == ST_CAPTURE) ||
                    ((r_state == ST_LINE_END) && !w_lastRow));

  // The byte seen together with the rising href is byte 0 of the line;
  // bytes beyond a full line are discarded
  assign w_byteValid = !w_abort && href &&
                       ((r_state == ST_WAIT_HREF) ||
                        ((r_state == ST_CAPTURE) && !w_lineFull));
  assign w_clear     = (r_state == ST_LINE_END) || w_abort;

  assign w_keepRow = ((32'(r_row) % DECIM) == 0);
  assign w_keepCol = ((32'(r_col) % DECIM) == 0);
  assign w_write   = w_pixComplete && w_keepRow && w_keepCol &&
                     (32'(r_nextAddr) < FRAME_PIXELS);

  cam_byte_packer #(
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL)
  ) u_packer (
    .i_pclk        (pclk),
    .i_rst         (rst),
    .i_clear       (w_clear),
    .i_byteValid   (w_byteValid),
    .i_data        (data),
    .o_pixComplete (w_pixComplete),
    .o_pixel       (w_pixel)
  );

  // FSM state register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // FSM next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:        if (enable)      w_nextState = ST_WAIT_VS;
      ST_WAIT_VS:     if (w_vsActive)  w_nextState = ST_WAIT_VS_END;
      ST_WAIT_VS_END: if (!w_vsActive) w_nextState = ST_WAIT_HREF;
      ST_WAIT_HREF: begin
        if (w_abort)   w_nextState = ST_WAIT_VS_END;
        else if (href) w_nextState = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_abort)    w_nextState = ST_WAIT_VS_END;
        else if (!href) w_nextState = ST_LINE_END;
      end
      ST_LINE_END: begin
        if (w_lastRow)    w_nextState = enable ? ST_WAIT_VS : ST_IDLE;
        else if (w_abort) w_nextState = ST_WAIT_VS_END;
        else              w_nextState = ST_WAIT_HREF;
      end
      default:            w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: write stream, row/col/address bookkeeping, pulses and errors.
  // An abort is applied last so it overrides any bookkeeping in that cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      we          <= 1'b0;
      addr        <= '0;
      pixel       <= 16'h0000;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_abort   <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_nextAddr  <= '0;
      r_rowBase   <= '0;
    end else begin
      we          <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (w_write) begin
        we         <= 1'b1;
        addr       <= r_nextAddr;
        pixel      <= w_pixel;
        r_nextAddr <= r_nextAddr + ADDR_W'(1);
      end
      if (w_pixComplete) r_col <= r_col + COL_W'(1);

      case (r_state)
        ST_WAIT_VS: if (w_vsActive) busy <= 1'b1;
        ST_WAIT_HREF: begin
          if (!w_abort && href && (r_row == '0)) begin
            frame_start <= 1'b1;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_abort   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!w_abort) begin
            if (href && w_lineFull)   err_long  <= 1'b1;
            if (!href && !w_lineFull) err_short <= 1'b1;
          end
        end
        ST_LINE_END: begin
          if (w_lastRow) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_nextAddr <= '0;
            r_rowBase  <= '0;
            addr       <= '0;
          end else begin
            r_row <= r_row + ROW_W'(1);
            r_col <= '0;
            // Re-align from the row base so a short line cannot shift later rows
            if (w_keepRow) begin
              r_rowBase  <= r_rowBase + ADDR_W'(H_OUT);
              r_nextAddr <= r_rowBase + ADDR_W'(H_OUT);
            end
          end
        end
        default: ;
      endcase

      if (w_abort) begin
        err_abort  <= 1'b1;
        r_row      <= '0;
        r_col      <= '0;
        r_nextAddr <= '0;
        r_rowBase  <= '0;
        addr       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_capture
// Three cam_capture instances with different geometries share one stimulus
// bus; href/vsync are routed only to the instance under test. A byte-level
// model pushes expected writes into a queue, which is popped as the selected
// instance raises we.
// ---------------------------------------------------------------------------
module tb_cam_capture;

  localparam int ADDR_W = 17;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       pix;
  } wr_t;

  typedef struct {
    int sel;
    int lb0, lb1, lb2, lb3;
    int expWrites;
    int expLastAddr;
    int expLastPix;
    bit expShort;
    bit expLong;
  } vec_t;

  logic       pclk = 1'b0;
  logic       rst, enable, vsync, href;
  logic [7:0] data;
  int         sel;

  logic [2:0] hrefG, vsG;
  logic              weS    [3];
  logic [ADDR_W-1:0] addrS  [3];
  logic [15:0]       pixelS [3];
  logic              fsS [3], fdS [3], busyS [3], esS [3], elS [3], eaS [3];

  int cfgH   [3] = '{4, 4, 4};
  int cfgV   [3] = '{3, 3, 4};
  int cfgBpp [3] = '{2, 1, 2};
  int cfgDec [3] = '{1, 1, 2};

  wr_t  sbQ[$];
  vec_t vecs[6];
  int   nChecks = 0, nFails = 0;
  int   writeCount = 0, startCount = 0, doneCount = 0;
  logic [ADDR_W-1:0] lastAddr;
  logic [15:0]       lastPix;
  logic [7:0]        prevByte;
  logic [7:0]        byteCtr;

  always #5 pclk = ~pclk;

  // Only the selected instance sees sensor activity; others idle in WAIT_VS
  assign hrefG[0] = href  && (sel == 0);
  assign hrefG[1] = href  && (sel == 1);
  assign hrefG[2] = href  && (sel == 2);
  assign vsG[0]   = vsync && (sel == 0);
  assign vsG[1]   = vsync && (sel == 1);
  assign vsG[2]   = vsync && (sel == 2);

  cam_capture #(.H_FRAME(4), .V_FRAME(3), .BYTES_PER_PIXEL(2), .DECIM(1), .ADDR_W(ADDR_W), .VSYNC_POL(1'b1)) dutA (
    .pclk(pclk), .rst(rst), .enable(enable), .vsync(vsG[0]), .href(hrefG[0]), .data(data),
    .we(weS[0]), .addr(addrS[0]), .pixel(pixelS[0]), .frame_start(fsS[0]), .frame_done(fdS[0]),
    .busy(busyS[0]), .err_short(esS[0]), .err_long(elS[0]), .err_abort(eaS[0]));

  cam_capture #(.H_FRAME(4), .V_FRAME(3), .BYTES_PER_PIXEL(1), .DECIM(1), .ADDR_W(ADDR_W), .VSYNC_POL(1'b1)) dutB (
    .pclk(pclk), .rst(rst), .enable(enable), .vsync(vsG[1]), .href(hrefG[1]), .data(data),
    .we(weS[1]), .addr(addrS[1]), .pixel(pixelS[1]), .frame_start(fsS[1]), .frame_done(fdS[1]),
    .busy(busyS[1]), .err_short(esS[1]), .err_long(elS[1]), .err_abort(eaS[1]));

  cam_capture #(.H_FRAME(4), .V_FRAME(4), .BYTES_PER_PIXEL(2), .DECIM(2), .ADDR_W(ADDR_W), .VSYNC_POL(1'b1)) dutC (
    .pclk(pclk), .rst(rst), .enable(enable), .vsync(vsG[2]), .href(hrefG[2]), .data(data),
    .we(weS[2]), .addr(addrS[2]), .pixel(pixelS[2]), .frame_start(fsS[2]), .frame_done(fdS[2]),
    .busy(busyS[2]), .err_short(esS[2]), .err_long(elS[2]), .err_abort(eaS[2]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called once per cycle at the falling edge: scoreboard the write stream
  task automatic sampleOutputs();
    wr_t expWr;
    if (weS[sel]) begin
      writeCount++;
      lastAddr = addrS[sel];
      lastPix  = pixelS[sel];
      checkOutput("sb_pending", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        expWr = sbQ.pop_front();
        checkOutput("wr_addr", 32'(addrS[sel]), 32'(expWr.addr));
        checkOutput("wr_pixel", 32'(pixelS[sel]), 32'(expWr.pix));
      end
    end
    if (fsS[sel]) startCount++;
    if (fdS[sel]) doneCount++;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic h, input logic v);
    @(negedge pclk);
    sampleOutputs();
    data  = d;
    href  = h;
    vsync = v;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  // Reference model for one sensor byte of a given row/byte index
  task automatic modelByte(input int row, input int b, input logic [7:0] val);
    int col, hh, dd;
    logic done;
    logic [15:0] pix;
    hh = cfgH[sel];
    dd = cfgDec[sel];
    done = 1'b0;
    col = 0;
    pix = 16'h0000;
    if (cfgBpp[sel] == 1) begin
      done = 1'b1; col = b; pix = {8'h00, val};
    end else if (b % 2 == 1) begin
      done = 1'b1; col = b / 2; pix = {prevByte, val};
    end else begin
      prevByte = val;
    end
    if (done && col < hh && (row % dd) == 0 && (col % dd) == 0)
      sbQ.push_back('{addr: ADDR_W'((row / dd) * (hh / dd) + col / dd), pix: pix});
  endtask

  task automatic driveBytes(input int row, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      modelByte(row, b, byteCtr);
      applyStimulus(byteCtr, 1'b1, 1'b0);
      byteCtr++;
    end
  endtask

  task automatic driveLine(input int row, input int nbytes);
    driveBytes(row, nbytes);
    idleCycles(3);
  endtask

  task automatic vsyncPulse();
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b1);
    idleCycles(3);
  endtask

  task automatic runRecord(input int idx, input vec_t v);
    int ws, ss, ds;
    int lb[4];
    lb = '{v.lb0, v.lb1, v.lb2, v.lb3};
    ws = writeCount; ss = startCount; ds = doneCount;
    sel = v.sel;
    byteCtr = 8'd1;
    vsyncPulse();
    for (int r = 0; r < cfgV[v.sel]; r++) driveLine(r, lb[r]);
    idleCycles(5);
    checkOutput($sformatf("r%0d_writes", idx), 32'(writeCount - ws), 32'(v.expWrites));
    checkOutput($sformatf("r%0d_last_addr", idx), 32'(lastAddr), 32'(v.expLastAddr));
    checkOutput($sformatf("r%0d_last_pixel", idx), 32'(lastPix), 32'(v.expLastPix));
    checkOutput($sformatf("r%0d_starts", idx), 32'(startCount - ss), 32'd1);
    checkOutput($sformatf("r%0d_dones", idx), 32'(doneCount - ds), 32'd1);
    checkOutput($sformatf("r%0d_err_short", idx), 32'(esS[v.sel]), 32'(v.expShort));
    checkOutput($sformatf("r%0d_err_long", idx), 32'(elS[v.sel]), 32'(v.expLong));
    checkOutput($sformatf("r%0d_err_abort", idx), 32'(eaS[v.sel]), 32'd0);
    checkOutput($sformatf("r%0d_busy", idx), 32'(busyS[v.sel]), 32'd0);
    checkOutput($sformatf("r%0d_sb_empty", idx), 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    int ws, ss, ds;

    // sel, row byte counts, writes, last addr, last pixel, short, long
    vecs[0] = '{sel:0, lb0:8,  lb1:8, lb2:8, lb3:0, expWrites:12, expLastAddr:11, expLastPix:'h1718, expShort:0, expLong:0};
    vecs[1] = '{sel:1, lb0:4,  lb1:4, lb2:4, lb3:0, expWrites:12, expLastAddr:11, expLastPix:'h000C, expShort:0, expLong:0};
    vecs[2] = '{sel:2, lb0:8,  lb1:8, lb2:8, lb3:8, expWrites:4,  expLastAddr:3,  expLastPix:'h1516, expShort:0, expLong:0};
    vecs[3] = '{sel:0, lb0:8,  lb1:6, lb2:8, lb3:0, expWrites:11, expLastAddr:11, expLastPix:'h1516, expShort:1, expLong:0};
    vecs[4] = '{sel:0, lb0:10, lb1:8, lb2:8, lb3:0, expWrites:12, expLastAddr:11, expLastPix:'h191A, expShort:0, expLong:1};
    vecs[5] = '{sel:0, lb0:8,  lb1:7, lb2:8, lb3:0, expWrites:11, expLastAddr:11, expLastPix:'h1617, expShort:1, expLong:0};

    rst = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00; sel = 0;
    repeat (3) @(negedge pclk);

    // Reset state of every instance
    checkOutput("rst_we", 32'(weS[0]), 32'd0);
    checkOutput("rst_addr", 32'(addrS[0]), 32'd0);
    checkOutput("rst_pixel", 32'(pixelS[0]), 32'd0);
    checkOutput("rst_busy", 32'(busyS[0]), 32'd0);
    checkOutput("rst_flags_a", 32'({fsS[0], fdS[0], esS[0], elS[0], eaS[0]}), 32'd0);
    checkOutput("rst_all_b", 32'({weS[1], addrS[1], pixelS[1], fsS[1], fdS[1], busyS[1], esS[1], elS[1], eaS[1]}), 32'd0);
    checkOutput("rst_all_c", 32'({weS[2], addrS[2], pixelS[2], fsS[2], fdS[2], busyS[2], esS[2], elS[2], eaS[2]}), 32'd0);

    rst = 1'b0;
    enable = 1'b1;
    idleCycles(3);

    for (int i = 0; i < 6; i++) runRecord(i, vecs[i]);

    // vsync during row 1 aborts; capture restarts without a new vsync pulse
    $display("[TB] abort sequence");
    sel = 0;
    ws = writeCount; ss = startCount; ds = doneCount;
    byteCtr = 8'd1;
    vsyncPulse();
    driveLine(0, 8);
    driveBytes(1, 3);
    applyStimulus(8'h55, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    idleCycles(3);
    checkOutput("abort_flag", 32'(eaS[0]), 32'd1);
    checkOutput("abort_busy", 32'(busyS[0]), 32'd1);
    checkOutput("abort_no_done", 32'(doneCount - ds), 32'd0);
    checkOutput("abort_writes", 32'(writeCount - ws), 32'd5);
    byteCtr = 8'd1;
    for (int r = 0; r < 3; r++) driveLine(r, 8);
    idleCycles(5);
    checkOutput("abort_restart_starts", 32'(startCount - ss), 32'd2);
    checkOutput("abort_restart_dones", 32'(doneCount - ds), 32'd1);
    checkOutput("abort_cleared", 32'(eaS[0]), 32'd0);
    checkOutput("abort_last_addr", 32'(lastAddr), 32'd11);
    checkOutput("abort_sb_empty", 32'(sbQ.size()), 32'd0);

    // enable dropped mid-frame: frame completes, then the block parks in IDLE
    $display("[TB] enable deassert sequence");
    ws = writeCount; ss = startCount; ds = doneCount;
    byteCtr = 8'd1;
    vsyncPulse();
    driveLine(0, 8);
    enable = 1'b0;
    driveLine(1, 8);
    driveLine(2, 8);
    idleCycles(5);
    checkOutput("en_off_dones", 32'(doneCount - ds), 32'd1);
    checkOutput("en_off_writes", 32'(writeCount - ws), 32'd12);
    vsyncPulse();
    checkOutput("en_off_idle_busy", 32'(busyS[0]), 32'd0);
    for (int b = 0; b < 8; b++) applyStimulus(8'hA0 + 8'(b), 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("en_off_no_start", 32'(startCount - ss), 32'd1);
    checkOutput("en_off_no_writes", 32'(writeCount - ws), 32'd12);
    enable = 1'b1;
    idleCycles(3);

    // Reset in the middle of a line returns everything to zero immediately
    $display("[TB] reset mid-frame sequence");
    byteCtr = 8'd1;
    vsyncPulse();
    driveBytes(0, 4);
    @(negedge pclk);
    sampleOutputs();
    #1;
    checkOutput("pre_rst_busy", 32'(busyS[0]), 32'd1);
    checkOutput("pre_rst_addr", 32'(addrS[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_outputs", 32'({weS[0], pixelS[0], fsS[0], fdS[0], busyS[0], esS[0], elS[0], eaS[0]}), 32'd0);
    checkOutput("mid_rst_addr", 32'(addrS[0]), 32'd0);
    href = 1'b0;
    data = 8'h00;
    repeat (2) @(negedge pclk);
    #2;
    rst = 1'b0;
    idleCycles(3);
    checkOutput("post_rst_sb_empty", 32'(sbQ.size()), 32'd0);
    runRecord(6, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
